// File: rtl/core2_cpu_0_jtag_debug_host.sv
// Host-side virtual-JTAG scan engine: takes one IR/DR command, walks
// UIR -> CDR -> SDR -> UDR with a divided TCK, and returns the captured DR.
module core2_cpu_0_jtag_debug_host #(
  parameter int unsigned TCK_DIV = 2,
  parameter int unsigned DR_LEN  = 38
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_ir,
  input  logic [DR_LEN-1:0] cmd_dr,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DR_LEN-1:0] rsp_dr,
  output logic [1:0]        rsp_ir_out,

  output logic              vji_tck,
  output logic              vji_tdi,
  output logic              vji_rti,
  output logic              vji_uir,
  output logic              vji_cdr,
  output logic              vji_sdr,
  output logic              vji_udr,
  output logic [1:0]        vji_ir_in,

  input  logic              vji_tdo,
  input  logic [1:0]        vji_ir_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RESP
  } state_e;

  localparam logic [7:0] DivLast = 8'(TCK_DIV - 1);
  localparam logic [5:0] BitLast = 6'(DR_LEN - 1);

  state_e            state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic              tck_q, tck_d;
  logic [5:0]        bit_q, bit_d;
  logic [DR_LEN-1:0] sh_q, sh_d;
  logic [DR_LEN-1:0] rsp_dr_q, rsp_dr_d;
  logic [1:0]        ir_q, ir_d;
  logic [1:0]        rsp_ir_q, rsp_ir_d;

  logic scanning;
  logic phase_end;
  logic tck_rise;
  logic period_end;

  assign scanning   = (state_q == S_UIR) || (state_q == S_CDR) ||
                      (state_q == S_SDR) || (state_q == S_UDR);
  assign phase_end  = (div_q == DivLast);
  // Every state change lands on period_end, so each state opens with TCK low.
  assign tck_rise   = scanning && !tck_q && phase_end;
  assign period_end = scanning &&  tck_q && phase_end;

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    tck_d    = tck_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    ir_d     = ir_q;
    rsp_dr_d = rsp_dr_q;
    rsp_ir_d = rsp_ir_q;

    if (scanning) begin
      if (phase_end) begin
        div_d = '0;
        tck_d = !tck_q;
      end else begin
        div_d = div_q + 8'd1;
      end
    end

    // TDO is sampled on the cycle that raises TCK; TDI follows sh[0].
    if ((state_q == S_SDR) && tck_rise) begin
      sh_d = {vji_tdo, sh_q[DR_LEN-1:1]};
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ir_d    = cmd_ir;
          sh_d    = cmd_dr;
          state_d = S_UIR;
        end
      end
      S_UIR: begin
        if (period_end) begin
          rsp_ir_d = vji_ir_out;
          state_d  = S_CDR;
        end
      end
      S_CDR: begin
        if (period_end) state_d = S_SDR;
      end
      S_SDR: begin
        if (period_end) begin
          if (bit_q == BitLast) begin
            bit_d   = '0;
            state_d = S_UDR;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end
      end
      S_UDR: begin
        if (period_end) begin
          rsp_dr_d = sh_q;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      tck_q    <= 1'b0;
      bit_q    <= '0;
      sh_q     <= '0;
      ir_q     <= '0;
      rsp_dr_q <= '0;
      rsp_ir_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tck_q    <= tck_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      ir_q     <= ir_d;
      rsp_dr_q <= rsp_dr_d;
      rsp_ir_q <= rsp_ir_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_dr     = rsp_dr_q;
  assign rsp_ir_out = rsp_ir_q;

  assign vji_tck    = tck_q;
  assign vji_tdi    = (state_q == S_SDR) && sh_q[0];
  assign vji_rti    = (state_q == S_IDLE) || (state_q == S_RESP);
  assign vji_uir    = (state_q == S_UIR);
  assign vji_cdr    = (state_q == S_CDR);
  assign vji_sdr    = (state_q == S_SDR);
  assign vji_udr    = (state_q == S_UDR);
  assign vji_ir_in  = ir_q;

endmodule
